// File: rtl/warp_mem_arbiter.sv
// Two-port read arbiter: fetch (F) and load (L) share one memory read port.
// Fetch has priority; a saturating starvation counter forces a load grant.
module warp_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_ren,
    input  logic [63:0] i_f_raddr,
    output logic        o_f_valid,
    output logic [63:0] o_f_rdata,
    input  logic        i_l_ren,
    input  logic [63:0] i_l_raddr,
    output logic        o_l_valid,
    output logic [63:0] o_l_rdata,
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_ready,
    input  logic [63:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    localparam logic [7:0] LIMIT_C = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    logic        pend_f_r;
    logic        pend_l_r;
    logic [63:0] pend_f_addr_r;
    logic [63:0] pend_l_addr_r;
    logic [63:0] mem_addr_r;
    logic        owner_r;
    logic [7:0]  starve_cnt_r;

    logic        cand_f_s;
    logic        cand_l_s;
    logic        any_cand_s;
    logic        sel_en_s;
    logic        grant_s;
    logic        win_l_s;
    logic [63:0] sel_addr_s;

    // Candidate qualification and winner selection; a same-cycle pulse bypasses its slot
    always_comb begin
        cand_f_s   = pend_f_r | i_f_ren;
        cand_l_s   = pend_l_r | i_l_ren;
        any_cand_s = cand_f_s | cand_l_s;
        sel_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: sel_en_s = 1'b1;
            ST_WAIT: sel_en_s = i_mem_valid;
            default: sel_en_s = 1'b0;
        endcase
        grant_s = sel_en_s & any_cand_s;
        win_l_s = (cand_l_s && (starve_cnt_r == LIMIT_C)) || !cand_f_s;
        if (win_l_s) begin
            if (i_l_ren) begin
                sel_addr_s = i_l_raddr;
            end else begin
                sel_addr_s = pend_l_addr_r;
            end
        end else begin
            if (i_f_ren) begin
                sel_addr_s = i_f_raddr;
            end else begin
                sel_addr_s = pend_f_addr_r;
            end
        end
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a response with a waiting candidate chains straight into REQ
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_cand_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (i_mem_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (i_mem_valid) begin
                    if (any_cand_s) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs: request from state, response valids steered to the recorded owner
    always_comb begin
        o_mem_req  = (state_r == ST_REQ);
        o_f_valid  = i_mem_valid & (state_r == ST_WAIT) & ~owner_r;
        o_l_valid  = i_mem_valid & (state_r == ST_WAIT) & owner_r;
        o_f_rdata  = i_mem_rdata;
        o_l_rdata  = i_mem_rdata;
        o_mem_addr = mem_addr_r;
    end

    // Pending slots: latest pulse wins; a granted slot clears even if it pulsed this cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_f_r      <= 1'b0;
            pend_l_r      <= 1'b0;
            pend_f_addr_r <= 64'd0;
            pend_l_addr_r <= 64'd0;
        end else begin
            if (grant_s && !win_l_s) begin
                pend_f_r <= 1'b0;
            end else if (i_f_ren) begin
                pend_f_r      <= 1'b1;
                pend_f_addr_r <= i_f_raddr;
            end else begin
                pend_f_r <= pend_f_r;
            end
            if (grant_s && win_l_s) begin
                pend_l_r <= 1'b0;
            end else if (i_l_ren) begin
                pend_l_r      <= 1'b1;
                pend_l_addr_r <= i_l_raddr;
            end else begin
                pend_l_r <= pend_l_r;
            end
        end
    end

    // Issued address and owner, held until the next grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_addr_r <= 64'd0;
            owner_r    <= 1'b0;
        end else if (grant_s) begin
            mem_addr_r <= sel_addr_s;
            owner_r    <= win_l_s;
        end else begin
            mem_addr_r <= mem_addr_r;
            owner_r    <= owner_r;
        end
    end

    // Starvation counter: counts F wins over a waiting L, saturating at the limit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            starve_cnt_r <= 8'd0;
        end else if (!cand_l_s) begin
            starve_cnt_r <= 8'd0;
        end else if (grant_s && win_l_s) begin
            starve_cnt_r <= 8'd0;
        end else if (grant_s && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_warp_mem_arbiter.sv
// Directed bench for warp_mem_arbiter: inputs driven at negedge, outputs sampled #1 later.
module tb_warp_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_ren;
    logic [63:0] f_raddr;
    logic        f_valid;
    logic [63:0] f_rdata;
    logic        l_ren;
    logic [63:0] l_raddr;
    logic        l_valid;
    logic [63:0] l_rdata;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        mem_valid;

    int n_checks;
    int n_pass;

    warp_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_f_ren     (f_ren),
        .i_f_raddr   (f_raddr),
        .o_f_valid   (f_valid),
        .o_f_rdata   (f_rdata),
        .i_l_ren     (l_ren),
        .i_l_raddr   (l_raddr),
        .o_l_valid   (l_valid),
        .o_l_rdata   (l_rdata),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .i_mem_ready (mem_ready),
        .i_mem_rdata (mem_rdata),
        .i_mem_valid (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_ren = 1'b0; l_ren = 1'b0; f_raddr = 64'd0; l_raddr = 64'd0;
        mem_ready = 1'b1; mem_rdata = 64'hDEAD; mem_valid = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", mem_req); else n_pass++;
        n_checks++;
        if (mem_addr !== 64'd0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++;
        if (f_valid !== 1'b0 || l_valid !== 1'b0)
            $display("FAIL reset_valid: got f=%0b l=%0b want 0 0", f_valid, l_valid);
        else n_pass++;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (f_valid !== 1'b0 || l_valid !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL idle_ignore_valid: got f=%0b l=%0b req=%0b want 0 0 0", f_valid, l_valid, mem_req);
        else n_pass++;
        mem_valid = 1'b0;
        step();
    endtask

    task automatic test_fetch_basic();
        f_ren = 1'b1; f_raddr = 64'h8000000000000000; mem_ready = 1'b1;
        step();
        f_ren = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h8000000000000000)
            $display("FAIL fetch_issue: got req=%0b addr=%h want 1 8000000000000000", mem_req, mem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL fetch_wait_req: got %0b want 0", mem_req); else n_pass++;
        mem_valid = 1'b1; mem_rdata = 64'h1122334455667788;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || l_valid !== 1'b0 || f_rdata !== 64'h1122334455667788)
            $display("FAIL fetch_resp: got f=%0b l=%0b data=%h want 1 0 1122334455667788", f_valid, l_valid, f_rdata);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL fetch_idle: got req=%0b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_simultaneous();
        f_ren = 1'b1; f_raddr = 64'h100; l_ren = 1'b1; l_raddr = 64'h200;
        step();
        f_ren = 1'b0; l_ren = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h100)
            $display("FAIL simul_first: got req=%0b addr=%h want 1 100", mem_req, mem_addr);
        else n_pass++;
        step();
        mem_valid = 1'b1; mem_rdata = 64'hAAAA;
        #1;
        n_checks++;
        if (f_valid !== 1'b1 || l_valid !== 1'b0)
            $display("FAIL simul_f_resp: got f=%0b l=%0b want 1 0", f_valid, l_valid);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h200)
            $display("FAIL simul_second: got req=%0b addr=%h want 1 200", mem_req, mem_addr);
        else n_pass++;
        step();
        mem_valid = 1'b1; mem_rdata = 64'hBBBB;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || l_valid !== 1'b1 || l_rdata !== 64'hBBBB)
            $display("FAIL simul_l_resp: got f=%0b l=%0b data=%h want 0 1 bbbb", f_valid, l_valid, l_rdata);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL simul_idle: got req=%0b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_starvation();
        f_ren = 1'b1; f_raddr = 64'h1000; l_ren = 1'b1; l_raddr = 64'h2000;
        step();
        f_ren = 1'b0; l_ren = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 64'h1000 + 64'(k))
                $display("FAIL starve_f%0d: got req=%0b addr=%h want 1 %h", k, mem_req, mem_addr, 64'h1000 + 64'(k));
            else n_pass++;
            step();
            mem_valid = 1'b1; f_ren = 1'b1; f_raddr = 64'h1000 + 64'(k + 1);
            #1;
            n_checks++;
            if (f_valid !== 1'b1) $display("FAIL starve_fresp%0d: got %0b want 1", k, f_valid); else n_pass++;
            step();
            mem_valid = 1'b0; f_ren = 1'b0;
            #1;
        end
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h2000)
            $display("FAIL starve_l_fifth: got req=%0b addr=%h want 1 2000", mem_req, mem_addr);
        else n_pass++;
        step();
        mem_valid = 1'b1;
        #1;
        n_checks++;
        if (l_valid !== 1'b1 || f_valid !== 1'b0)
            $display("FAIL starve_l_resp: got f=%0b l=%0b want 0 1", f_valid, l_valid);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h1004)
            $display("FAIL starve_f_after: got req=%0b addr=%h want 1 1004", mem_req, mem_addr);
        else n_pass++;
        step();
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        #1;
    endtask

    task automatic test_ready_stall();
        f_ren = 1'b1; f_raddr = 64'h400; mem_ready = 1'b0;
        step();
        f_ren = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_valid = (k == 1);
            #1;
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 64'h400 || f_valid !== 1'b0)
                $display("FAIL stall_c%0d: got req=%0b addr=%h fv=%0b want 1 400 0", k, mem_req, mem_addr, f_valid);
            else n_pass++;
            step();
        end
        mem_valid = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h400)
            $display("FAIL stall_ready: got req=%0b addr=%h want 1 400", mem_req, mem_addr);
        else n_pass++;
        step();
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL stall_wait: got req=%0b want 0", mem_req); else n_pass++;
        mem_valid = 1'b1;
        #1;
        n_checks++;
        if (f_valid !== 1'b1) $display("FAIL stall_resp: got %0b want 1", f_valid); else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
    endtask

    task automatic test_overwrite();
        l_ren = 1'b1; l_raddr = 64'h500;
        step();
        l_ren = 1'b0; f_ren = 1'b1; f_raddr = 64'h300;
        step();
        f_raddr = 64'h340;
        step();
        f_ren = 1'b0; mem_valid = 1'b1;
        #1;
        n_checks++;
        if (l_valid !== 1'b1 || f_valid !== 1'b0)
            $display("FAIL ovw_l_resp: got f=%0b l=%0b want 0 1", f_valid, l_valid);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 64'h340)
            $display("FAIL ovw_issue: got req=%0b addr=%h want 1 340", mem_req, mem_addr);
        else n_pass++;
        step();
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL ovw_single: got req=%0b want 0", mem_req); else n_pass++;
    endtask

    task automatic test_reset_mid();
        f_ren = 1'b1; f_raddr = 64'h600;
        step();
        f_ren = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 64'd0)
            $display("FAIL rstmid_clear: got req=%0b addr=%h want 0 0", mem_req, mem_addr);
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        mem_valid = 1'b1; mem_rdata = 64'h77;
        #1;
        n_checks++;
        if (f_valid !== 1'b0 || l_valid !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL rstmid_drop: got f=%0b l=%0b req=%0b want 0 0 0", f_valid, l_valid, mem_req);
        else n_pass++;
        step();
        mem_valid = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || mem_addr !== 64'd0)
            $display("FAIL rstmid_idle: got req=%0b addr=%h want 0 0", mem_req, mem_addr);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fetch_basic();
        test_simultaneous();
        test_starvation();
        test_ready_stall();
        test_overwrite();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
